// File: rtl/mem_responder_pkg.sv
// Shared core package: memory request format, responder FSM states and vector
// register file constants.
package mem_responder_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;
  localparam int ID_WIDTH   = 6;

  localparam int NUM_VREGS      = 32;
  localparam int VLEN           = 128;
  localparam int VREG_IDX_WIDTH = $clog2(NUM_VREGS);

  typedef struct packed {
    logic                  valid;
    logic                  write;
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } request_t;

  // Request payload as buffered: valid is implied by FIFO occupancy.
  localparam int REQ_PAYLOAD_WIDTH = $bits(request_t) - 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_t;

endpackage

// File: rtl/mem_responder_req_fifo.sv
// Request buffer: circular store with wrap-around pointers; an extra phase bit
// per pointer tells full from empty. Head word is visible without a pop.
module req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_data,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_data,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [IDX_W-1:0] r_wr_idx;
  logic [IDX_W-1:0] r_rd_idx;
  logic             r_wr_phase;
  logic             r_rd_phase;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(DEPTH - 1)) ? '0 : idx + 1'b1;
  endfunction

  assign o_empty   = (r_wr_idx == r_rd_idx) && (r_wr_phase == r_rd_phase);
  assign o_full    = (r_wr_idx == r_rd_idx) && (r_wr_phase != r_rd_phase);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_idx];
  assign w_do_pop  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_idx   <= '0;
      r_rd_idx   <= '0;
      r_wr_phase <= 1'b0;
      r_rd_phase <= 1'b0;
      r_count    <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_idx <= next_idx(r_wr_idx);
        if (r_wr_idx == IDX_W'(DEPTH - 1)) r_wr_phase <= ~r_wr_phase;
      end
      if (w_do_pop) begin
        r_rd_idx <= next_idx(r_rd_idx);
        if (r_rd_idx == IDX_W'(DEPTH - 1)) r_rd_phase <= ~r_rd_phase;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_idx] <= i_data;
  end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory model: buffers core requests, serves them in order after
// MEM_LATENCY cycles and returns one single-cycle response each.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int MEM_DEPTH      = 1024,
  parameter int MEM_LATENCY    = 4,
  parameter int REQ_FIFO_DEPTH = 64
) (
  input  logic     clk,
  input  logic     reset,
  input  request_t mem_req,
  output request_t mem_rsp,
  output logic     overflow_err
);

  // MEM_DEPTH is a power of two so the low address bits give the wrap.
  localparam int             MEM_AW   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int             FIFO_CW  = $clog2(REQ_FIFO_DEPTH + 1);
  localparam logic [3:0]     LAT_INIT = 4'(MEM_LATENCY - 1);

  state_t                r_state;
  logic [3:0]            r_lat_cnt;
  logic                  r_hold_write;
  logic [ID_WIDTH-1:0]   r_hold_id;
  logic [ADDR_WIDTH-1:0] r_hold_addr;
  logic [DATA_WIDTH-1:0] r_hold_data;
  logic                  r_rsp_valid;
  logic                  r_rsp_write;
  logic [ID_WIDTH-1:0]   r_rsp_id;
  logic [ADDR_WIDTH-1:0] r_rsp_addr;
  logic [DATA_WIDTH-1:0] r_rsp_wdata;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_overflow;
  logic [DATA_WIDTH-1:0] r_store [MEM_DEPTH];

  logic [REQ_PAYLOAD_WIDTH-1:0] w_push_data;
  logic [REQ_PAYLOAD_WIDTH-1:0] w_head;
  logic                         w_head_write;
  logic [ID_WIDTH-1:0]          w_head_id;
  logic [ADDR_WIDTH-1:0]        w_head_addr;
  logic [DATA_WIDTH-1:0]        w_head_data;
  logic                         w_full;
  logic                         w_empty;
  logic [FIFO_CW-1:0]           w_fifo_count_unused;
  logic                         w_pop;
  logic                         w_overflow;
  logic                         w_access;
  logic [MEM_AW-1:0]            w_idx;

  assign w_push_data = {mem_req.write, mem_req.id, mem_req.addr, mem_req.data};
  assign {w_head_write, w_head_id, w_head_addr, w_head_data} = w_head;

  req_fifo #(
    .WIDTH (REQ_PAYLOAD_WIDTH),
    .DEPTH (REQ_FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (mem_req.valid),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_fifo_count_unused)
  );

  assign w_pop      = ((r_state == IDLE) || (r_state == RESPOND)) && !w_empty;
  assign w_overflow = mem_req.valid && w_full && !w_pop;
  assign w_access   = (r_state == ACCESS);
  assign w_idx      = r_hold_addr[MEM_AW-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_lat_cnt    <= '0;
      r_hold_write <= 1'b0;
      r_hold_id    <= '0;
      r_hold_addr  <= '0;
      r_hold_data  <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_write  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_addr   <= '0;
      r_rsp_wdata  <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (w_overflow) r_overflow <= 1'b1;
      case (r_state)
        IDLE, RESPOND: begin
          if (w_pop) begin
            r_hold_write <= w_head_write;
            r_hold_id    <= w_head_id;
            r_hold_addr  <= w_head_addr;
            r_hold_data  <= w_head_data;
            r_lat_cnt    <= LAT_INIT;
            r_state      <= ACCESS;
          end else begin
            r_state <= IDLE;
          end
        end
        ACCESS: begin
          if (r_lat_cnt == '0) begin
            r_state     <= RESPOND;
            r_rsp_valid <= 1'b1;
            r_rsp_write <= r_hold_write;
            r_rsp_id    <= r_hold_id;
            r_rsp_addr  <= r_hold_addr;
            r_rsp_wdata <= r_hold_data;
          end else begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Single-port store: writes land on the first ACCESS cycle, reads sample on the last.
  always_ff @(posedge clk) begin
    if (w_access && r_hold_write && (r_lat_cnt == LAT_INIT)) begin
      r_store[w_idx] <= r_hold_data;
    end else if (w_access && !r_hold_write && (r_lat_cnt == '0)) begin
      r_rd_data <= r_store[w_idx];
    end
  end

  always_comb begin
    mem_rsp = '0;
    if (r_rsp_valid) begin
      mem_rsp.valid = 1'b1;
      mem_rsp.write = r_rsp_write;
      mem_rsp.id    = r_rsp_id;
      mem_rsp.addr  = r_rsp_addr;
      mem_rsp.data  = r_rsp_write ? r_rsp_wdata : r_rd_data;
    end
  end

  assign overflow_err = r_overflow;

endmodule
